// File: rtl/bus_arbiter4.sv
// Four-requester round-robin arbiter for one shared slave port, with a
// per-grant busy timeout and one-cycle done/timeout pulses back to the requester.
module bus_arbiter4 #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       mem_ready,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       mem_valid,
    output logic       busy,
    output logic [3:0] done,
    output logic [3:0] timeout
);

    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    // Counter value on the last permitted BUSY cycle; unused when TIMEOUT is 0.
    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LP_CNT_MAX  = '1;

    state_t           r_state, w_state_next;
    logic [1:0]       r_sel, w_sel_next;
    logic [1:0]       r_last, w_last_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [3:0]       r_done, w_done_next;
    logic [3:0]       r_timeout, w_timeout_next;
    logic [1:0]       w_winner;
    logic [3:0]       w_sel_onehot;

    assign w_sel_onehot = 4'b0001 << r_sel;

    // Scan from farthest offset to nearest so the nearest asserted index after last wins.
    always_comb begin : p_round_robin
        logic [1:0] v_idx;
        w_winner = r_last;
        v_idx    = r_last;
        for (int k = 4; k >= 1; k--) begin
            v_idx = r_last + 2'(k);
            if (req[v_idx]) begin
                w_winner = v_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_sel     <= 2'd0;
            r_last    <= 2'd3;
            r_cnt     <= '0;
            r_done    <= 4'b0000;
            r_timeout <= 4'b0000;
        end else begin
            r_state   <= w_state_next;
            r_sel     <= w_sel_next;
            r_last    <= w_last_next;
            r_cnt     <= w_cnt_next;
            r_done    <= w_done_next;
            r_timeout <= w_timeout_next;
        end
    end

    // Exit priority in BUSY: completion, then requester drop, then timeout.
    always_comb begin
        w_state_next   = r_state;
        w_sel_next     = r_sel;
        w_last_next    = r_last;
        w_cnt_next     = r_cnt;
        w_done_next    = 4'b0000;
        w_timeout_next = 4'b0000;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_state_next = S_BUSY;
                    w_sel_next   = w_winner;
                    w_cnt_next   = '0;
                end
            end
            S_BUSY: begin
                if (mem_ready) begin
                    w_state_next = S_IDLE;
                    w_done_next  = w_sel_onehot;
                    w_last_next  = r_sel;
                end else if (!req[r_sel]) begin
                    w_state_next = S_IDLE;
                    w_last_next  = r_sel;
                end else if ((TIMEOUT != 0) && (r_cnt == LP_CNT_LAST)) begin
                    w_state_next   = S_IDLE;
                    w_timeout_next = w_sel_onehot;
                    w_last_next    = r_sel;
                end else if (r_cnt != LP_CNT_MAX) begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy      = (r_state == S_BUSY);
        mem_valid = busy;
        grant     = busy ? w_sel_onehot : 4'b0000;
        sel       = r_sel;
        done      = r_done;
        timeout   = r_timeout;
    end

endmodule

// File: tb/tb_bus_arbiter4.sv
// Directed bench for bus_arbiter4: stimulus pushes expected grant/done/timeout
// events into a queue, a negedge monitor pops and compares as the DUT emits them.
module tb_bus_arbiter4;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       mem_ready;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       mem_valid;
    logic       busy;
    logic [3:0] done;
    logic [3:0] timeout;

    bus_arbiter4 #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .mem_ready (mem_ready),
        .grant     (grant),
        .sel       (sel),
        .mem_valid (mem_valid),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;  // 0 grant, 1 done, 2 timeout
        logic [3:0] val;
        logic [1:0] idx;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic push_ev(input int kind, input int idx);
        exp_t e;
        e.kind = kind;
        e.idx  = 2'(idx);
        e.val  = 4'b0001 << e.idx;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input int kind, input logic [3:0] v, input logic [1:0] s);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: kind %0d value %b, expected no event", kind, v);
        end else begin
            e = exp_q.pop_front();
            $display("[%0t] event kind=%0d value=%b sel=%0d", $time, kind, v, s);
            chk("event_kind", 32'(kind), 32'(e.kind));
            chk("event_value", 32'(v), 32'(e.val));
            if (e.kind == 0) chk("event_sel", 32'(s), 32'(e.idx));
        end
    endtask

    logic [3:0] prev_grant = 4'b0000;
    logic       prev_busy  = 1'b0;
    logic [1:0] prev_sel   = 2'd0;

    always @(negedge clk) begin
        if (!rst) begin
            chk("grant_onehot_sel", 32'(grant), 32'(busy ? (4'b0001 << sel) : 4'b0000));
            chk("pulse_exclusive", 32'((done != 0) && (timeout != 0)), 32'(0));
            chk("pulse_onehot0", 32'($onehot0(done) && $onehot0(timeout)), 32'(1));
            if (prev_busy && busy) chk("sel_stable", 32'(sel), 32'(prev_sel));
            if (grant != 0 && prev_grant == 0) pop_cmp(0, grant, sel);
            if (done != 0) pop_cmp(1, done, sel);
            if (timeout != 0) pop_cmp(2, timeout, sel);
        end
        prev_grant = grant;
        prev_busy  = busy;
        prev_sel   = sel;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_busy();
        int n = 0;
        while (!busy && n < 10) begin
            tick();
            n++;
        end
        n_checks++;
        if (!busy) begin
            n_fail++;
            $display("FAIL wait_busy: busy=%0b after %0d cycles, required 1", busy, n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        req = 4'b0000;
        mem_ready = 1'b0;
        #12;
        chk("rst_grant", 32'(grant), 0);
        chk("rst_sel", 32'(sel), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_mem_valid", 32'(mem_valid), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_timeout", 32'(timeout), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Round robin with all requesting, completion one cycle after each grant.
        for (int i = 0; i < 5; i++) begin
            push_ev(0, i % 4);
            push_ev(1, i % 4);
        end
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_busy();
            chk("rr_sel", 32'(sel), 32'(i % 4));
            mem_ready = 1'b1;
            tick();
            mem_ready = 1'b0;
            if (i == 4) req = 4'b0000;
        end
        tick();

        // Single requester 2, completion at the third edge after grant.
        push_ev(0, 2);
        push_ev(1, 2);
        req = 4'b0100;
        tick();
        chk("single_grant", 32'(grant), 32'(4'b0100));
        chk("single_sel", 32'(sel), 2);
        chk("single_valid", 32'(mem_valid), 1);
        tick();
        tick();
        mem_ready = 1'b1;
        req = 4'b0000;
        tick();
        chk("single_done", 32'(done), 32'(4'b0100));
        chk("single_busy_clr", 32'(busy), 0);
        mem_ready = 1'b0;
        tick();
        chk("single_done_1cyc", 32'(done), 0);

        // Timeout of requester 1, then regrant after one idle cycle.
        push_ev(0, 1);
        push_ev(2, 1);
        push_ev(0, 1);
        req = 4'b0010;
        tick();
        n = 0;
        while (busy && n < 20) begin
            n++;
            tick();
        end
        chk("to_busy_cycles", 32'(n), 32'(TO));
        chk("to_pulse", 32'(timeout), 32'(4'b0010));
        chk("to_idle", 32'(busy), 0);
        tick();
        chk("to_regrant", 32'(grant), 32'(4'b0010));
        chk("to_pulse_1cyc", 32'(timeout), 0);
        req = 4'b0000;
        tick();
        chk("drop1_busy", 32'(busy), 0);
        chk("drop1_done", 32'(done), 0);
        chk("drop1_timeout", 32'(timeout), 0);

        // Requester 3 drops mid-grant; next winner from 1001 must be 0.
        push_ev(0, 3);
        req = 4'b1000;
        tick();
        chk("drop_sel3", 32'(sel), 3);
        tick();
        req = 4'b0000;
        tick();
        chk("drop_busy", 32'(busy), 0);
        chk("drop_done", 32'(done), 0);
        chk("drop_timeout", 32'(timeout), 0);
        push_ev(0, 0);
        push_ev(1, 0);
        req = 4'b1001;
        tick();
        chk("after_drop_sel", 32'(sel), 0);
        mem_ready = 1'b1;
        req = 4'b0000;
        tick();
        mem_ready = 1'b0;
        tick();

        // Completion and drop on the timeout cycle: done only.
        push_ev(0, 1);
        push_ev(1, 1);
        req = 4'b0010;
        tick();
        tick();
        tick();
        tick();
        mem_ready = 1'b1;
        req = 4'b0000;
        tick();
        chk("race_done", 32'(done), 32'(4'b0010));
        chk("race_timeout", 32'(timeout), 0);
        mem_ready = 1'b0;
        tick();
        chk("race_no_late_to", 32'(timeout), 0);

        // Asynchronous reset mid-BUSY, then priority restarts at requester 0.
        push_ev(0, 2);
        req = 4'b0100;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_grant", 32'(grant), 0);
        chk("arst_valid", 32'(mem_valid), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_sel", 32'(sel), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        req = 4'b0000;
        tick();
        chk("arst_no_done", 32'(done), 0);
        chk("arst_no_timeout", 32'(timeout), 0);
        push_ev(0, 0);
        push_ev(1, 0);
        req = 4'b1001;
        tick();
        chk("arst_first_sel", 32'(sel), 0);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        push_ev(0, 3);
        push_ev(1, 3);
        req = 4'b1000;
        wait_busy();
        chk("arst_req3_sel", 32'(sel), 3);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        req = 4'b0000;
        tick();
        tick();

        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter4.md
BUS_ARBITER4 -- requirements
Module: bus_arbiter4

Interface
REQ-001 The block SHALL expose parameter TIMEOUT, default 16, meaning the maximum number of BUSY cycles per grant, with 0 disabling the timeout.
REQ-002 The block SHALL expose parameter CNT_W, default 8, meaning the width of the timeout counter, with TIMEOUT < 2^CNT_W.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-005 req  input  4  request per requester; bit i = requester i wants the shared port.
REQ-006 mem_ready  input  1  shared slave completion; sampled only in BUSY.
REQ-007 grant  output  4  one-hot grant, or all-zero.
REQ-008 sel  output  2  index of the granted requester; drives the 4:1 select of the shared-port input mux.
REQ-009 mem_valid  output  1  transaction active toward the slave.
REQ-010 busy  output  1  high in BUSY state.
REQ-011 done  output  4  one-cycle pulse to requester i on completion.
REQ-012 timeout  output  4  one-cycle pulse to requester i on timeout abort.

Function
REQ-013 The block SHALL implement two states, IDLE and BUSY, plus a 2-bit register last (the last granted index) and a CNT_W-bit counter cnt.
REQ-014 In IDLE with req != 0, the block SHALL select the winner by round-robin: scan indices last+1, last+2, last+3, last (mod 4), pick the first asserted, and then register grant/sel, set cnt=0, and enter BUSY on that edge.
REQ-015 Grant latency SHALL be exactly one cycle: req sampled in IDLE at edge N, grant visible after edge N.
REQ-016 In IDLE with req == 0, all outputs SHALL stay 0 and last SHALL hold; sel SHALL hold its previous value.
REQ-017 In BUSY, grant SHALL equal onehot(sel), and mem_valid and busy SHALL be 1, and grant/sel SHALL NOT change until BUSY exits.
REQ-018 BUSY with mem_ready=1 at the edge SHALL: pulse done[sel] for the following cycle, set last=sel, clear grant/mem_valid/busy, and enter IDLE.
REQ-019 BUSY with req[sel] deasserted at the edge and mem_ready=0 SHALL abort: enter IDLE, set last=sel, no done, no timeout pulse.
REQ-020 BUSY with TIMEOUT!=0, cnt==TIMEOUT-1, mem_ready=0, and req[sel]=1 SHALL pulse timeout[sel], set last=sel, and enter IDLE; otherwise cnt SHALL increment by 1 per BUSY cycle without wrap.
REQ-021 Simultaneous events SHALL resolve with priority mem_ready > requester drop > timeout.
REQ-022 After every BUSY exit the block SHALL spend at least one cycle in IDLE, so back-to-back grants are separated by one bubble cycle.
REQ-023 done and timeout SHALL never both be nonzero in the same cycle, and each SHALL have at most one bit set.
REQ-024 Requests arriving in BUSY SHALL be ignored until IDLE, with no queuing.
REQ-025 With TIMEOUT=0, cnt SHALL saturate at 2^CNT_W-1 and the block SHALL never pulse timeout.

Reset
REQ-026 rst=1 SHALL immediately, without waiting for clk, force IDLE with grant=0, sel=0, mem_valid=0, busy=0, done=0, timeout=0, cnt=0, and last=3 (requester 0 has first priority).
REQ-027 Reset asserted mid-BUSY SHALL drop the grant asynchronously and emit no done or timeout pulse.
REQ-028 The first edge after rst deasserts SHALL be treated as an ordinary IDLE evaluation.

Verification
REQ-029 Reset, then req=4'b1111 held, mem_ready pulsed one cycle after each grant -> grant order 0,1,2,3,0 with sel 0,1,2,3,0 and done pulses in the same order.
REQ-030 req=4'b0100 at edge N -> grant=4'b0100, sel=2, mem_valid=1 after N; mem_ready at N+3 -> done=4'b0100 for one cycle, busy=0.
REQ-031 TIMEOUT=4, req=4'b0010 held, mem_ready=0 -> exactly 4 BUSY cycles, then timeout=4'b0010 pulse, IDLE for one cycle, re-grant of requester 1 (the only requester).
REQ-032 Grant to requester 3, then req[3] dropped with mem_ready=0 -> IDLE next cycle, no done or timeout, last=3, and the next winner from req=4'b1001 is requester 0.
REQ-033 At TIMEOUT-1, assert mem_ready and drop req in the same cycle -> done pulse only.
REQ-034 rst asserted asynchronously between clk edges while BUSY -> grant=0 and mem_valid=0 before the next edge, and a later req=4'b1000 is granted only after the priority order from index 0 finds no earlier request.
